// File: rtl/tamagotchi_input_ctrl_pkg.sv
// Shared definitions for the pet front-end: command codes, controller states
// and the bit positions of each button inside btn_level.
package tamagotchi_pkg;

    typedef logic [2:0] cmd_id_t;

    localparam cmd_id_t CMD_SALUD     = 3'd0;
    localparam cmd_id_t CMD_ENERGIA   = 3'd1;
    localparam cmd_id_t CMD_HAMBRE    = 3'd2;
    localparam cmd_id_t CMD_DIVERSION = 3'd3;
    localparam cmd_id_t CMD_RESET     = 3'd4;
    localparam cmd_id_t CMD_TEST      = 3'd5;

    localparam int NUM_BTN       = 6;
    localparam int BTN_SALUD     = 0;
    localparam int BTN_ENERGIA   = 1;
    localparam int BTN_HAMBRE    = 2;
    localparam int BTN_DIVERSION = 3;
    localparam int BTN_RESET     = 4;
    localparam int BTN_TEST      = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        ISSUE    = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

endpackage

// File: rtl/tamagotchi_input_ctrl_if.sv
// Command handshake between the button front-end (master) and the pet FSM (slave).
interface tamagotchi_input_ctrl_if;
    import tamagotchi_pkg::*;

    logic    cmd_valid;
    logic    cmd_ready;
    cmd_id_t cmd_id;

    modport master (output cmd_valid, output cmd_id, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_id, output cmd_ready);

endinterface

// File: rtl/tamagotchi_input_ctrl_debounce.sv
// One button lane: 2-flop synchronizer followed by a stable-count debouncer
// that only flips the level after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 28
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized input agrees with the level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = ~level_q;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/tamagotchi_input_ctrl.sv
// Button front-end for the pet FSM: debounces six buttons, qualifies reset/test
// as long presses, and hands out one prioritized command per press.
module tamagotchi_input_ctrl
    import tamagotchi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 250000000,
    parameter int CNT_W             = 28
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btn_salud,
    input  logic                       btn_energia,
    input  logic                       btn_hambre,
    input  logic                       btn_diversion,
    input  logic                       btn_reset,
    input  logic                       btn_test,
    input  logic                       ledsign,
    tamagotchi_input_ctrl_if.master    cmd,
    output logic [NUM_BTN-1:0]         btn_level,
    output logic                       busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);

    logic [NUM_BTN-1:0] raw;
    logic               led_s1_q, led_s2_q;
    state_e             state_q, state_d;
    cmd_id_t            id_q, id_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               held_level;

    assign raw = {btn_test, btn_reset, btn_diversion, btn_hambre, btn_energia, btn_salud};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (raw[i]),
            .level_o(btn_level[i])
        );
    end

    // ledsign is a slow status level, so synchronizing is enough; no debounce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_s1_q <= 1'b0;
            led_s2_q <= 1'b0;
        end else begin
            led_s1_q <= ledsign;
            led_s2_q <= led_s1_q;
        end
    end

    assign held_level = (id_q == CMD_RESET) ? btn_level[BTN_RESET] : btn_level[BTN_TEST];

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (btn_level[BTN_RESET]) begin
                    id_d    = CMD_RESET;
                    hold_d  = '0;
                    state_d = HOLD;
                end else if (btn_level[BTN_TEST]) begin
                    id_d    = CMD_TEST;
                    hold_d  = '0;
                    state_d = HOLD;
                end else if (btn_level[BTN_SALUD]) begin
                    id_d    = CMD_SALUD;
                    state_d = ISSUE;
                end else if (btn_level[BTN_ENERGIA] && led_s2_q) begin
                    id_d    = CMD_ENERGIA;
                    state_d = ISSUE;
                end else if (btn_level[BTN_HAMBRE]) begin
                    id_d    = CMD_HAMBRE;
                    state_d = ISSUE;
                end else if (btn_level[BTN_DIVERSION]) begin
                    id_d    = CMD_DIVERSION;
                    state_d = ISSUE;
                end
            end
            HOLD: begin
                if (held_level) begin
                    hold_d = (hold_q == '1) ? hold_q : hold_q + HOLD_ONE;
                    if (hold_d >= HOLD_LAST) begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = WAIT_REL;
                end
            end
            ISSUE: begin
                if (cmd.cmd_ready) begin
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                // Waiting for every button to clear also swallows arbitration losers.
                if (btn_level == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= CMD_SALUD;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            hold_q  <= hold_d;
        end
    end

    assign cmd.cmd_valid = (state_q == ISSUE);
    assign cmd.cmd_id    = id_q;
    assign busy          = (state_q != IDLE);

endmodule
